// File: rtl/i2s_buffer_scheduler_pkg.sv
// Shared definitions for the wb_i2s ping-pong buffer scheduler: state encoding
// and default widths used by the scheduler and its buffer slots.
package i2s_buffer_scheduler_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_SIZE_WIDTH = 24;
  localparam int unsigned DATA_WIDTH     = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_PAD    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/i2s_buffer_slot.sv
// One host-loaded playback buffer: ready flag, base, size and read offset.
// Arms are ignored while ready; an arm coinciding with a retire lands a cycle late.
module i2s_buffer_slot
  import i2s_buffer_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned SIZE_WIDTH = DEF_SIZE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [SIZE_WIDTH-1:0] size_i,
  input  logic                  advance_i,
  input  logic                  retire_i,
  output logic                  ready_o,
  output logic                  last_word_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic                  ready_q, ready_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [SIZE_WIDTH-1:0] offset_q, offset_d;
  logic                  arm_ok;

  assign arm_ok = arm_i && (size_i != '0) && !pend_q;

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no path can infer a latch.
    ready_d  = ready_q;
    pend_d   = 1'b0;
    base_d   = base_q;
    size_d   = size_q;
    offset_d = offset_q;
    if (advance_i) offset_d = offset_q + SIZE_WIDTH'(1);
    if (retire_i) begin
      ready_d  = 1'b0;
      offset_d = '0;
    end
    if (pend_q) ready_d = 1'b1;
    if (arm_ok && (!ready_q || retire_i)) begin
      base_d = base_i;
      size_d = size_i;
      if (retire_i) pend_d = 1'b1;
      else          ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst) begin
      ready_q  <= 1'b0;
      pend_q   <= 1'b0;
      base_q   <= '0;
      size_q   <= '0;
      offset_q <= '0;
    end else begin
      ready_q  <= ready_d;
      pend_q   <= pend_d;
      base_q   <= base_d;
      size_q   <= size_d;
      offset_q <= offset_d;
    end
  end

  assign ready_o     = ready_q;
  assign last_word_o = (offset_q + SIZE_WIDTH'(1)) == size_q;
  assign addr_o      = base_q + ADDR_WIDTH'(offset_q);

endmodule

// File: rtl/i2s_buffer_scheduler.sv
// Answers I2S burst requests by reading words from two ping-pong buffers in
// strict alternation, zero-padding when the active buffer is not armed.
module i2s_buffer_scheduler
  import i2s_buffer_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned SIZE_WIDTH = DEF_SIZE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] buf_base_0,
  input  logic [ADDR_WIDTH-1:0] buf_base_1,
  input  logic [SIZE_WIDTH-1:0] buf_size_0,
  input  logic [SIZE_WIDTH-1:0] buf_size_1,
  input  logic [1:0]            buf_arm,
  output logic [1:0]            buf_ready,
  output logic [1:0]            buf_done,
  output logic                  underrun,
  input  logic                  underrun_clr,
  input  logic                  request_data,
  input  logic [SIZE_WIDTH-1:0] request_size,
  output logic                  request_finished,
  output logic [31:0]           memory_data,
  output logic                  memory_data_strobe,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_valid,
  input  logic [31:0]           mem_rd_data
);

  state_e                state_q, state_d;
  logic                  active_q, active_d;
  logic [SIZE_WIDTH-1:0] remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  strobe_q, strobe_d;
  logic [1:0]            done_q, done_d;
  logic                  underrun_q, underrun_d;
  logic                  finished_q, finished_d;
  logic                  fin_seen_q;
  logic [1:0]            advance, retire, slot_ready, slot_last;
  logic [ADDR_WIDTH-1:0] slot_addr_0, slot_addr_1;

  i2s_buffer_slot #(.ADDR_WIDTH(ADDR_WIDTH), .SIZE_WIDTH(SIZE_WIDTH)) u_slot_0 (
    .clk(clk), .rst(rst), .arm_i(buf_arm[0]), .base_i(buf_base_0), .size_i(buf_size_0),
    .advance_i(advance[0]), .retire_i(retire[0]), .ready_o(slot_ready[0]),
    .last_word_o(slot_last[0]), .addr_o(slot_addr_0)
  );

  i2s_buffer_slot #(.ADDR_WIDTH(ADDR_WIDTH), .SIZE_WIDTH(SIZE_WIDTH)) u_slot_1 (
    .clk(clk), .rst(rst), .arm_i(buf_arm[1]), .base_i(buf_base_1), .size_i(buf_size_1),
    .advance_i(advance[1]), .retire_i(retire[1]), .ready_o(slot_ready[1]),
    .last_word_o(slot_last[1]), .addr_o(slot_addr_1)
  );

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    strobe_d    = 1'b0;
    done_d      = 2'b00;
    underrun_d  = underrun_q & ~underrun_clr;
    advance     = 2'b00;
    retire      = 2'b00;
    // The finish pulse lands one cycle after entering FINISH, i.e. after the last strobe.
    finished_d  = (state_q == ST_FINISH) && !fin_seen_q && enable;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (request_data) begin
          remaining_d = request_size;
          if (request_size == '0)      state_d = ST_FINISH;
          else if (slot_ready[active_q]) state_d = ST_ISSUE;
          else                           state_d = ST_PAD;
        end
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT: if (mem_rd_valid) begin
          strobe_d            = 1'b1;
          data_d              = mem_rd_data;
          advance[active_q]   = 1'b1;
          remaining_d         = remaining_q - SIZE_WIDTH'(1);
          if (slot_last[active_q]) begin
            retire[active_q] = 1'b1;
            done_d[active_q] = 1'b1;
            active_d         = ~active_q;
          end
          if (remaining_d == '0)         state_d = ST_FINISH;
          else if (slot_ready[active_d]) state_d = ST_ISSUE;
          else                           state_d = ST_PAD;
        end
        ST_PAD: begin
          strobe_d    = 1'b1;
          data_d      = '0;
          underrun_d  = 1'b1;
          remaining_d = remaining_q - SIZE_WIDTH'(1);
          if (remaining_d == '0)         state_d = ST_FINISH;
          else if (slot_ready[active_q]) state_d = ST_ISSUE;
          else                           state_d = ST_PAD;
        end
        ST_FINISH: if (!request_data) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      active_q    <= 1'b0;
      remaining_q <= '0;
      data_q      <= '0;
      strobe_q    <= 1'b0;
      done_q      <= 2'b00;
      underrun_q  <= 1'b0;
      finished_q  <= 1'b0;
      fin_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      finished_q  <= finished_d;
      fin_seen_q  <= (state_q == ST_FINISH);
    end
  end

  assign mem_rd_en          = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign mem_rd_addr        = !mem_rd_en ? '0 : (active_q ? slot_addr_1 : slot_addr_0);
  assign buf_ready          = slot_ready;
  assign buf_done           = done_q;
  assign underrun           = underrun_q;
  assign request_finished   = finished_q;
  assign memory_data        = data_q;
  assign memory_data_strobe = strobe_q;

endmodule

// File: tb/tb_i2s_buffer_scheduler.sv
// Directed self-checking bench for i2s_buffer_scheduler with a variable-latency
// memory model and a negedge monitor that records strobes, addresses and pulses.
module tb_i2s_buffer_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic [31:0] buf_base_0 = '0, buf_base_1 = '0;
  logic [23:0] buf_size_0 = '0, buf_size_1 = '0;
  logic [1:0]  buf_arm = '0;
  logic [1:0]  buf_ready, buf_done;
  logic        underrun;
  logic        underrun_clr = 1'b0;
  logic        request_data = 1'b0;
  logic [23:0] request_size = '0;
  logic        request_finished;
  logic [31:0] memory_data;
  logic        memory_data_strobe;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;

  i2s_buffer_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable),
    .buf_base_0(buf_base_0), .buf_base_1(buf_base_1),
    .buf_size_0(buf_size_0), .buf_size_1(buf_size_1),
    .buf_arm(buf_arm), .buf_ready(buf_ready), .buf_done(buf_done),
    .underrun(underrun), .underrun_clr(underrun_clr),
    .request_data(request_data), .request_size(request_size),
    .request_finished(request_finished),
    .memory_data(memory_data), .memory_data_strobe(memory_data_strobe),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Memory answers after `lat` cycles of a held request; data is address + 0x1000_0000.
  int lat = 1;
  int wcnt = 0;
  assign mem_rd_valid = mem_rd_en && (wcnt == lat);
  assign mem_rd_data  = mem_rd_addr + 32'h1000_0000;
  always @(posedge clk) begin
    if (!mem_rd_en || mem_rd_valid) wcnt <= 0;
    else                            wcnt <= wcnt + 1;
  end

  logic [31:0] words[$];
  logic [1:0]  dones[$];
  logic [31:0] addrs[$];
  int          fin_cnt = 0, en_cycles = 0, addr_changes = 0;
  logic        fin_prev_strobe = 1'b0;
  logic        prev_strobe = 1'b0, prev_en = 1'b0, prev_valid = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (memory_data_strobe) begin
      words.push_back(memory_data);
      dones.push_back(buf_done);
    end
    if (request_finished) begin
      fin_cnt         <= fin_cnt + 1;
      fin_prev_strobe <= prev_strobe;
    end
    if (mem_rd_en && mem_rd_valid) addrs.push_back(mem_rd_addr);
    if (mem_rd_en) en_cycles <= en_cycles + 1;
    if (mem_rd_en && prev_en && !prev_valid && (mem_rd_addr != prev_addr))
      addr_changes <= addr_changes + 1;
    prev_strobe <= memory_data_strobe;
    prev_en     <= mem_rd_en;
    prev_valid  <= mem_rd_valid;
    prev_addr   <= mem_rd_addr;
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; request_data = 1'b0; buf_arm = '0; enable = 1'b1;
    underrun_clr = 1'b0; lat = 1;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic arm(input int n, input logic [31:0] base, input logic [23:0] size);
    if (n == 0) begin buf_base_0 = base; buf_size_0 = size; buf_arm = 2'b01; end
    else        begin buf_base_1 = base; buf_size_1 = size; buf_arm = 2'b10; end
    tick(1);
    buf_arm = '0;
  endtask

  task automatic clear_logs();
    words.delete(); dones.delete(); addrs.delete();
  endtask

  task automatic wait_finish(input string tag, input int fc0);
    int cyc;
    cyc = 0;
    while (fin_cnt == fc0 && cyc < 200) begin tick(1); cyc++; end
    check(tag, 64'(fin_cnt - fc0), 64'd1);
    request_data = 1'b0;
    tick(2);
  endtask

  task automatic run_request(input logic [23:0] n, input string tag);
    int fc0;
    fc0 = fin_cnt;
    clear_logs();
    request_size = n;
    request_data = 1'b1;
    wait_finish(tag, fc0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc0, en0, ac0, cyc;

    // Reset state
    do_reset();
    check("rst_flags", 64'({buf_ready, buf_done, underrun, request_finished,
                            memory_data_strobe, mem_rd_en}), 64'd0);
    check("rst_data", 64'(memory_data), 64'd0);
    check("rst_addr", 64'(mem_rd_addr), 64'd0);

    // Single buffer drains exactly with the request
    arm(0, 32'h100, 24'd4);
    check("s1_ready", 64'(buf_ready), 64'h1);
    run_request(24'd4, "s1_finish");
    check("s1_nwords", 64'(words.size()), 64'd4);
    check("s1_w0", 64'(words[0]), 64'h1000_0100);
    check("s1_w3", 64'(words[3]), 64'h1000_0103);
    check("s1_a1", 64'(addrs[1]), 64'h101);
    check("s1_a3", 64'(addrs[3]), 64'h103);
    check("s1_done2", 64'(dones[2]), 64'h0);
    check("s1_done3", 64'(dones[3]), 64'h1);
    check("s1_fin_after_strobe", 64'(fin_prev_strobe), 64'h1);
    check("s1_ready_after", 64'(buf_ready), 64'h0);
    arm(0, 32'h400, 24'd1);
    arm(1, 32'h300, 24'd1);
    run_request(24'd1, "s1b_finish");
    check("s1_active1_addr", 64'(addrs[0]), 64'h300);
    check("s1_active1_done", 64'(dones[0]), 64'h2);

    // Alternation across buffers; re-arm of a ready slot is ignored
    do_reset();
    arm(0, 32'h100, 24'd3);
    arm(1, 32'h200, 24'd3);
    arm(0, 32'h900, 24'd5);
    check("s2_ready", 64'(buf_ready), 64'h3);
    run_request(24'd5, "s2_finish");
    check("s2_nwords", 64'(words.size()), 64'd5);
    check("s2_a0", 64'(addrs[0]), 64'h100);
    check("s2_a2", 64'(addrs[2]), 64'h102);
    check("s2_a3", 64'(addrs[3]), 64'h200);
    check("s2_a4", 64'(addrs[4]), 64'h201);
    check("s2_done2", 64'(dones[2]), 64'h1);
    check("s2_w4", 64'(words[4]), 64'h1000_0201);
    run_request(24'd1, "s2b_finish");
    check("s2b_a0", 64'(addrs[0]), 64'h202);
    check("s2b_done", 64'(dones[0]), 64'h2);

    // Nothing armed: pure padding; zero-size arm ignored
    do_reset();
    arm(0, 32'h700, 24'd0);
    check("s3_zero_arm", 64'(buf_ready), 64'h0);
    en0 = en_cycles;
    run_request(24'd3, "s3_finish");
    check("s3_nwords", 64'(words.size()), 64'd3);
    check("s3_w0", 64'(words[0]), 64'h0);
    check("s3_w2", 64'(words[2]), 64'h0);
    check("s3_underrun", 64'(underrun), 64'h1);
    check("s3_no_rd", 64'(en_cycles - en0), 64'd0);
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    check("s3_underrun_clr", 64'(underrun), 64'h0);

    // Drain buf0, pad, then buf1 armed mid-burst as soon as a pad word is seen
    do_reset();
    arm(0, 32'h100, 24'd2);
    fc0 = fin_cnt;
    clear_logs();
    request_size = 24'd6;
    request_data = 1'b1;
    cyc = 0;
    while (words.size() < 3 && cyc < 100) begin @(negedge clk); #1; cyc++; end
    check("s4_pad_seen", 64'(words.size()), 64'd3);
    buf_base_1 = 32'h200; buf_size_1 = 24'd8; buf_arm = 2'b10;
    @(posedge clk); #1;
    buf_arm = '0;
    wait_finish("s4_finish", fc0);
    check("s4_nwords", 64'(words.size()), 64'd6);
    check("s4_w1", 64'(words[1]), 64'h1000_0101);
    check("s4_done1", 64'(dones[1]), 64'h1);
    check("s4_w2", 64'(words[2]), 64'h0);
    check("s4_w4", 64'(words[4]), 64'h0);
    check("s4_w5", 64'(words[5]), 64'h1000_0200);
    check("s4_underrun", 64'(underrun), 64'h1);

    // Slow memory: request held stable while waiting
    do_reset();
    lat = 5;
    arm(0, 32'h500, 24'd2);
    en0 = en_cycles;
    ac0 = addr_changes;
    run_request(24'd1, "s5_finish");
    check("s5_en_cycles", 64'(en_cycles - en0), 64'd6);
    check("s5_addr_stable", 64'(addr_changes - ac0), 64'd0);
    check("s5_w0", 64'(words[0]), 64'h1000_0500);

    // Abort mid-WAIT: no finish pulse, offset preserved
    fc0 = fin_cnt;
    clear_logs();
    request_size = 24'd1;
    request_data = 1'b1;
    tick(3);
    check("s5_in_wait", 64'(mem_rd_en), 64'h1);
    enable = 1'b0;
    tick(1);
    check("s5_abort_en", 64'(mem_rd_en), 64'h0);
    tick(4);
    check("s5_abort_nofin", 64'(fin_cnt - fc0), 64'd0);
    check("s5_abort_nostrobe", 64'(words.size()), 64'd0);
    request_data = 1'b0;
    enable = 1'b1;
    lat = 1;
    tick(1);
    run_request(24'd1, "s5b_finish");
    check("s5_resume_addr", 64'(addrs[0]), 64'h501);
    check("s5_resume_done", 64'(dones[0]), 64'h1);

    // Reset mid-burst, then a zero-length request
    do_reset();
    arm(0, 32'h100, 24'd4);
    request_size = 24'd4;
    request_data = 1'b1;
    tick(4);
    rst = 1'b0;
    request_data = 1'b0;
    tick(1);
    check("s6_rst_flags", 64'({buf_ready, buf_done, underrun, request_finished,
                               memory_data_strobe, mem_rd_en}), 64'd0);
    check("s6_rst_data", 64'(memory_data), 64'd0);
    check("s6_rst_addr", 64'(mem_rd_addr), 64'd0);
    rst = 1'b1;
    tick(1);
    run_request(24'd0, "s6_zero_finish");
    check("s6_zero_nwords", 64'(words.size()), 64'd0);
    check("s6_zero_no_strobe_before", 64'(fin_prev_strobe), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
